// File: rtl/alu4_pkg.sv
// alu4_pkg: opcodes shared with the alu4 core and the scheduler FSM encoding
package alu4_pkg;
  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;
  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_AND = 3'd2;
  localparam op_t OP_OR  = 3'd3;
  localparam op_t OP_XOR = 3'd4;
  localparam op_t OP_NOT = 3'd5;
  localparam op_t OP_SHL = 3'd6;
  localparam op_t OP_SHR = 3'd7;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/alu4_scheduler_if.sv
// alu4_scheduler_if: requester, alu4 core and response signals of the scheduler
interface alu4_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int OP_W    = 3
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]  req_op;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [OP_W-1:0]          alu_op;
  logic [WIDTH-1:0]         alu_y;
  logic                     alu_cout;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_y;
  logic                     rsp_cout;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic                     busy;
  modport master (
    output req, req_a, req_b, req_op, alu_y, alu_cout, rsp_ready,
    input  gnt, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_cout, busy
  );
  modport slave (
    input  req, req_a, req_b, req_op, alu_y, alu_cout, rsp_ready,
    output gnt, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_cout, busy
  );
endinterface

// File: rtl/alu4_rr_pick.sv
// alu4_rr_pick: combinational round-robin pick, first request at or above ptr
module alu4_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);
  localparam int IW = $clog2(NUM_REQ);
  always_comb begin
    int idx;
    idx = 0;
    winner = '0;
    // scan from the farthest offset down so the nearest request to ptr wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) winner = IW'(idx);
    end
    any_req = |req;
  end
endmodule

// File: rtl/alu4_scheduler.sv
// alu4_scheduler: round-robin time-sharing of one combinational alu4 core
// between NUM_REQ requesters with a fixed settle time and valid/ready return
module alu4_scheduler
  import alu4_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu4_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win;
  logic               any_req;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   rsp_y;
  op_t                alu_op;
  logic               rsp_cout;
  alu4_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (win),
    .any_req (any_req)
  );
  assign bus.gnt       = gnt;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_op    = alu_op;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_cout  = rsp_cout;
  assign bus.busy      = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: if (any_req) begin
          alu_a  <= bus.req_a[win*WIDTH +: WIDTH];
          alu_b  <= bus.req_b[win*WIDTH +: WIDTH];
          alu_op <= bus.req_op[win*OP_W +: OP_W];
          gnt    <= NUM_REQ'(1) << win;
          owner  <= win;
          ptr    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          cnt    <= CW'(SETTLE_CYCLES - 1);
          state  <= ST_EXEC;
        end
        ST_EXEC: if (cnt == '0) begin
          rsp_y     <= bus.alu_y;
          rsp_cout  <= bus.alu_cout;
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= ST_RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        ST_RESP: if (bus.rsp_ready[owner]) begin
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
